// File: rtl/fpga_cam_wr_sched_if.sv
// Request and CAM-write bundle between requesters and the write scheduler.
// Latency: wires only. Backpressure: req_ready is the only throttle toward requesters.
// Ports: req_valid/req_ready handshake, per-requester addr/patt/mask/kbit,
//        done/busy status, cam_wEn + cam_wAddr/wPatt/wMask/wKbit to CAM port 0.
interface fpga_cam_wr_sched_if #(
  parameter int NREQ  = 4,
  parameter int AW    = 6,
  parameter int WIDTH = 36,
  parameter int KW    = 16
);
  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ-1:0][AW-1:0]     req_addr;
  logic [NREQ-1:0][WIDTH-1:0]  req_patt;
  logic [NREQ-1:0][WIDTH-1:0]  req_mask;
  logic [NREQ-1:0][KW-1:0]     req_kbit;
  logic [NREQ-1:0]             done;
  logic                        busy;
  logic                        cam_wEn;
  logic [AW-1:0]               cam_wAddr;
  logic [WIDTH-1:0]            cam_wPatt;
  logic [WIDTH-1:0]            cam_wMask;
  logic [KW-1:0]               cam_wKbit;

  // Requester side (and whatever observes the CAM write port).
  modport master (
    output req_valid, req_addr, req_patt, req_mask, req_kbit,
    input  req_ready, done, busy,
    input  cam_wEn, cam_wAddr, cam_wPatt, cam_wMask, cam_wKbit
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_addr, req_patt, req_mask, req_kbit,
    output req_ready, done, busy,
    output cam_wEn, cam_wAddr, cam_wPatt, cam_wMask, cam_wKbit
  );
endinterface

// File: rtl/fpga_cam_wr_sched.sv
// Round-robin scheduler that serialises requester writes onto the multi-cycle CAM write port.
// Latency: grant combinational in IDLE; cam_wEn for WCYC cycles, then SETTLE cycles, done on the last.
// Backpressure: req_ready held 0 outside IDLE; requesters keep valid asserted until granted.
// Ports: clk, rst (async, active-high), bus (slave modport: requests in, grant/done/busy/CAM write out).
module fpga_cam_wr_sched #(
  parameter int NREQ   = 4,
  parameter int AW     = 6,
  parameter int WIDTH  = 36,
  parameter int KW     = 16,
  parameter int WCYC   = 64,
  parameter int SETTLE = 2
) (
  input logic                clk,
  input logic                rst,
  fpga_cam_wr_sched_if.slave bus
);
  localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  // One counter serves both the write and settle phases, so size it for the longer one.
  localparam int CMAX = (WCYC > SETTLE) ? WCYC : SETTLE;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] WLAST = CW'(WCYC - 1);
  localparam logic [CW-1:0] SLAST = CW'(SETTLE - 1);
  localparam logic [GW-1:0] GMAX  = GW'(NREQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [GW-1:0]    ptr, ptr_nx;
  logic [GW-1:0]    grant_q;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] patt_q;
  logic [WIDTH-1:0] mask_q;
  logic [KW-1:0]    kbit_q;

  logic             found;
  logic [GW-1:0]    win;
  logic [GW-1:0]    idx;
  logic             capture;
  logic [NREQ-1:0]  ready;
  logic [NREQ-1:0]  done_pulse;

  // Round-robin pick: first valid requester at or after ptr, wrapping mod NREQ.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = GW'((int'(ptr) + i) % NREQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ptr   <= ptr_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    ptr_nx     = ptr;
    capture    = 1'b0;
    ready      = '0;
    done_pulse = '0;
    case (state)
      ST_IDLE: begin
        if (found) begin
          ready[win] = 1'b1;
          capture    = 1'b1;
          cnt_nx     = '0;
          state_nx   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (cnt == WLAST) begin
          cnt_nx   = '0;
          state_nx = ST_SETTLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt == SLAST) begin
          done_pulse[grant_q] = 1'b1;
          // Advancing past the winner is what keeps a continuously-valid requester
          // from being granted twice in a row while another is waiting.
          ptr_nx   = (grant_q == GMAX) ? '0 : grant_q + GW'(1);
          cnt_nx   = '0;
          state_nx = ST_IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Requester fields are sampled only at the handshake; the CAM sees these
  // registers, so later input changes cannot disturb a write in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= '0;
      addr_q  <= '0;
      patt_q  <= '0;
      mask_q  <= '0;
      kbit_q  <= '0;
    end else if (capture) begin
      grant_q <= win;
      addr_q  <= bus.req_addr[win];
      patt_q  <= bus.req_patt[win];
      mask_q  <= bus.req_mask[win];
      kbit_q  <= bus.req_kbit[win];
    end
  end

  // ready is combinational from req_valid, so it must also be forced low while
  // rst is held; everything else derives from async-reset state.
  assign bus.req_ready = rst ? '0 : ready;
  assign bus.done      = rst ? '0 : done_pulse;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.cam_wEn   = (state == ST_WRITE);
  assign bus.cam_wAddr = addr_q;
  assign bus.cam_wPatt = patt_q;
  assign bus.cam_wMask = mask_q;
  assign bus.cam_wKbit = kbit_q;
endmodule

// File: tb/tb_fpga_cam_wr_sched.sv
module tb_fpga_cam_wr_sched;
  localparam int NREQ   = 4;
  localparam int AW     = 6;
  localparam int WIDTH  = 36;
  localparam int KW     = 16;
  localparam int WCYC   = 64;
  localparam int SETTLE = 2;
  localparam int GAP    = WCYC + SETTLE + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fpga_cam_wr_sched_if #(.NREQ(NREQ), .AW(AW), .WIDTH(WIDTH), .KW(KW)) bus ();

  fpga_cam_wr_sched #(
    .NREQ(NREQ), .AW(AW), .WIDTH(WIDTH), .KW(KW), .WCYC(WCYC), .SETTLE(SETTLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change at posedge+1; outputs are sampled at posedge+2.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[i] = '0;
      bus.req_patt[i] = '0;
      bus.req_mask[i] = '0;
      bus.req_kbit[i] = '0;
    end
  endtask

  function automatic int oh2idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  int gq[$], gc[$], dq[$], dc[$];
  int multi;

  // Records grant/done events for n cycles with inputs held; cycle 0 is the entry cycle.
  task automatic monitor(input int n);
    gq.delete(); gc.delete(); dq.delete(); dc.delete();
    multi = 0;
    for (int c = 0; c < n; c++) begin
      #1;
      if (bus.req_ready != '0) begin
        gq.push_back(oh2idx(bus.req_ready));
        gc.push_back(c);
        if ($countones(bus.req_ready) != 1) multi++;
      end
      if (bus.done != '0) begin
        dq.push_back(oh2idx(bus.done));
        dc.push_back(c);
        if ($countones(bus.done) != 1) multi++;
      end
      tick();
    end
  endtask

  int errs;
  int exp_fair[4] = '{0, 2, 0, 2};

  initial begin
    // ---------------- reset state ----------------
    clear_inputs();
    bus.req_valid = 4'hF;
    #12;
    check("rst_ready", bus.req_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_wen", bus.cam_wEn, 0);
    check("rst_done", bus.done, 0);
    check("rst_waddr", bus.cam_wAddr, 0);
    check("rst_wpatt", bus.cam_wPatt, 0);

    // ---------------- single write ----------------
    clear_inputs();
    tick();
    rst = 1'b0;
    bus.req_valid   = 4'b0001;
    bus.req_addr[0] = 6'h10;
    bus.req_patt[0] = 36'h1234;
    bus.req_mask[0] = 36'h0;
    bus.req_kbit[0] = 16'h0001;
    #1;
    check("t1_ready", bus.req_ready, 4'b0001);
    check("t1_busy_idle", bus.busy, 0);
    tick();
    bus.req_valid = '0;
    errs = 0;
    for (int k = 1; k <= WCYC; k++) begin
      #1;
      if (bus.cam_wEn !== 1'b1 || bus.busy !== 1'b1 || bus.cam_wAddr !== 6'h10 ||
          bus.cam_wPatt !== 36'h1234 || bus.cam_wMask !== 36'h0 ||
          bus.cam_wKbit !== 16'h0001 || bus.req_ready !== '0 || bus.done !== '0)
        errs++;
      tick();
    end
    check("t1_write_window", errs, 0);
    #1;
    check("t1_wen_off", bus.cam_wEn, 0);
    check("t1_settle_busy", bus.busy, 1);
    check("t1_settle_patt", bus.cam_wPatt, 36'h1234);
    check("t1_no_early_done", bus.done, 0);
    tick();
    #1;
    check("t1_done", bus.done, 4'b0001);
    tick();
    #1;
    check("t1_idle_busy", bus.busy, 0);
    check("t1_done_gone", bus.done, 0);

    // ---------------- all four valid ----------------
    rst = 1'b1;
    clear_inputs();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[i] = AW'(8'h20 + i);
      bus.req_patt[i] = WIDTH'(36'h100 + i);
    end
    bus.req_valid = 4'hF;
    tick();
    rst = 1'b0;
    monitor(4 * GAP + 2);
    check("rr_grants", gq.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr_g%0d", i), qget(gq, i), i % NREQ);
      check($sformatf("rr_t%0d", i), qget(gc, i), GAP * i);
    end
    check("rr_dones", dq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_d%0d", i), qget(dq, i), i);
      check($sformatf("rr_dt%0d", i), qget(dc, i), GAP * i + WCYC + SETTLE);
    end
    check("rr_onehot", multi, 0);

    // ---------------- fairness 0 and 2 ----------------
    rst = 1'b1;
    clear_inputs();
    bus.req_valid = 4'b0101;
    tick();
    rst = 1'b0;
    monitor(4 * GAP);
    bus.req_valid = '0;
    check("fair_grants", gq.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("fair_g%0d", i), qget(gq, i), exp_fair[i]);
    check("fair_dones", dq.size(), 4);
    check("fair_onehot", multi, 0);

    // ---------------- reset mid-write (ptr is 3 here) ----------------
    bus.req_addr[1] = 6'h21;
    bus.req_patt[1] = 36'hABC;
    bus.req_valid   = 4'b0010;
    #1;
    check("mr_grant1", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid = '0;
    for (int k = 1; k < 20; k++) tick();
    #1;
    check("mr_wen_pre", bus.cam_wEn, 1);
    check("mr_addr_pre", bus.cam_wAddr, 6'h21);
    bus.req_valid = 4'b1010;
    rst = 1'b1;
    #1;
    check("mr_wen_async", bus.cam_wEn, 0);
    check("mr_busy_async", bus.busy, 0);
    check("mr_ready_async", bus.req_ready, 0);
    check("mr_addr_async", bus.cam_wAddr, 0);
    errs = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      if (bus.done !== '0 || bus.busy !== 1'b0 || bus.req_ready !== '0) errs++;
    end
    check("mr_hold_quiet", errs, 0);
    tick();
    rst = 1'b0;
    monitor(GAP);
    bus.req_valid = '0;
    check("mr_first_grant", qget(gq, 0), 1);
    check("mr_grant_cycle", qget(gc, 0), 0);
    check("mr_done_count", dq.size(), 1);
    check("mr_done_cycle", qget(dc, 0), WCYC + SETTLE);

    // ---------------- capture stability ----------------
    bus.req_addr[2] = 6'h2C;
    bus.req_patt[2] = 36'h5A5A;
    bus.req_valid   = 4'b0100;
    #1;
    check("cs_grant", bus.req_ready, 4'b0100);
    tick();
    bus.req_valid   = '0;
    bus.req_patt[2] = 36'hFFFF;
    bus.req_addr[2] = 6'h3F;
    errs = 0;
    for (int k = 1; k <= WCYC; k++) begin
      #1;
      if (bus.cam_wEn !== 1'b1 || bus.cam_wPatt !== 36'h5A5A || bus.cam_wAddr !== 6'h2C) errs++;
      tick();
    end
    check("cs_patt_hold", errs, 0);
    #1;
    check("cs_settle_patt", bus.cam_wPatt, 36'h5A5A);
    tick();
    tick();

    // ---------------- idle ----------------
    clear_inputs();
    errs = 0;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (bus.busy !== 1'b0 || bus.cam_wEn !== 1'b0 || bus.req_ready !== '0 || bus.done !== '0)
        errs++;
      tick();
    end
    check("idle_quiet", errs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
